// File: rtl/rr_req_buffer.sv
// -----------------------------------------------------------------------------
// rr_req_buffer
//
// Per-requester request buffer placed directly upstream of a round-robin
// arbiter. Each of num_reqs producers owns an independent circular FIFO.
// The buffer drives the arbiter's request vector from FIFO occupancy. It
// consumes the arbiter's registered one-hot grants to pop the granted head.
// The popped payload is forwarded, tagged with its port index, to the shared
// downstream resource one cycle after the grant.
//
// Parameters
//   num_reqs : number of requesters (>= 2), equal to the arbiter's num_reqs
//   DATA_W   : payload width per request
//   DEPTH    : entries per FIFO (power of two, >= 2)
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   in_valid   in   [num_reqs]          per-port push request
//   in_data    in   [num_reqs*DATA_W]   per-port payload, port i at [i*DATA_W +: DATA_W]
//   in_ready   out  [num_reqs]          per-port not-full (from registered count)
//   reqs       out  [num_reqs]          request vector to the arbiter
//   grants     in   [num_reqs]          registered one-hot grants from the arbiter
//   out_valid  out  1                   popped payload valid
//   out_port   out  [$clog2(num_reqs)]  index of the popped port
//   out_data   out  [DATA_W]            popped payload
//
// Optional feature (macro RR_REQ_BUF_ERR_EN)
//   err_sticky out  1   OR of err_code
//   err_code   out  2   sticky error flags: bit0 grant to empty port,
//                       bit1 multi-hot grant; cleared only by reset
// -----------------------------------------------------------------------------
module rr_req_buffer #(
    parameter int num_reqs = 4,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [num_reqs-1:0]          in_valid,
    input  logic [num_reqs*DATA_W-1:0]   in_data,
    output logic [num_reqs-1:0]          in_ready,
    output logic [num_reqs-1:0]          reqs,
    input  logic [num_reqs-1:0]          grants,
    output logic                         out_valid,
    output logic [$clog2(num_reqs)-1:0]  out_port,
    output logic [DATA_W-1:0]            out_data
`ifdef RR_REQ_BUF_ERR_EN
    ,
    output logic                         err_sticky,
    output logic [1:0]                   err_code
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PORT_W = $clog2(num_reqs);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ---------------------------------------------------------------------
    // Storage and per-port FIFO state
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem    [num_reqs][DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr [num_reqs];
    logic [PTR_W-1:0]  r_wr_ptr [num_reqs];
    logic [CNT_W-1:0]  r_count  [num_reqs];

    logic [num_reqs-1:0] w_nonempty;
    logic [num_reqs-1:0] w_push;
    logic [num_reqs-1:0] w_pop;
    logic                w_pop_any;
    logic [PORT_W-1:0]   w_pop_idx;
    logic [DATA_W-1:0]   w_head_data;

    logic                r_out_valid;
    logic [PORT_W-1:0]   r_out_port;
    logic [DATA_W-1:0]   r_out_data;

    // ---------------------------------------------------------------------
    // Push acceptance and request generation
    // ---------------------------------------------------------------------
    // in_ready looks only at the registered count, so a pop in the same
    // cycle never frees a slot for a same-cycle push.
    // reqs masks the port being granted this cycle: the arbiter answers a
    // request one cycle later, so a port whose last entry is being popped
    // must not request again. A same-cycle push is not counted until the
    // next cycle. grants is a flop output, so this path has no loop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        w_nonempty = '0;
        in_ready   = '0;
        w_push     = '0;
        reqs       = '0;
        for (int i = 0; i < num_reqs; i++) begin
            w_nonempty[i] = (r_count[i] != '0);
            in_ready[i]   = (r_count[i] != CNT_FULL);
            w_push[i]     = in_valid[i] && in_ready[i];
            reqs[i]       = (r_count[i] > CNT_W'(grants[i]));
        end
    end

    // ---------------------------------------------------------------------
    // Pop selection: lowest-index granted port that actually holds data.
    // A well-behaved arbiter grants one-hot, so this only matters for the
    // multi-hot error case. A grant to an empty port is simply ignored.
    // ---------------------------------------------------------------------
    always_comb begin
        w_pop     = '0;
        w_pop_any = 1'b0;
        w_pop_idx = '0;
        for (int i = 0; i < num_reqs; i++) begin
            if (!w_pop_any && grants[i] && w_nonempty[i]) begin
                w_pop[i]  = 1'b1;
                w_pop_any = 1'b1;
                w_pop_idx = PORT_W'(i);
            end
        end
    end

    always_comb begin
        w_head_data = r_mem[w_pop_idx][r_rd_ptr[w_pop_idx]];
    end

    // ---------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ---------------------------------------------------------------------
    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // natural overflow of the increment is the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < num_reqs; i++) begin
                // NOTE: sequential state is written with non-blocking
                // assignments so every flop samples pre-edge values.
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < num_reqs; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_ONE;
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_ONE;
                end
                // Push and pop together leave the count unchanged.
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_ONE;
                    2'b01:   r_count[i] <= r_count[i] - CNT_ONE;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // NOTE: the payload array has no reset; stale contents are never visible
    // because the reset pointers and counts mark every entry as empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < num_reqs; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output register: one cycle from grant to output. Port and data hold
    // their previous value when nothing is popped; only valid drops.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_port  <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_pop_any;
            if (w_pop_any) begin
                r_out_port <= w_pop_idx;
                r_out_data <= w_head_data;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_port  = r_out_port;
    assign out_data  = r_out_data;

`ifdef RR_REQ_BUF_ERR_EN
    // ---------------------------------------------------------------------
    // Sticky error flags, accumulated until reset.
    // ---------------------------------------------------------------------
    logic       w_err_empty;
    logic       w_err_multi;
    logic [1:0] r_err_code;

    always_comb begin
        w_err_empty = |(grants & ~w_nonempty);
        // Clearing the lowest set bit leaves something only if two or more
        // bits were set.
        w_err_multi = ((grants & (grants - num_reqs'(1))) != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_code <= 2'b00;
        end else begin
            r_err_code <= r_err_code | {w_err_multi, w_err_empty};
        end
    end

    assign err_code   = r_err_code;
    assign err_sticky = |r_err_code;
`endif

endmodule

// File: tb/tb_rr_req_buffer.sv
// -----------------------------------------------------------------------------
// tb_rr_req_buffer
//
// Directed testbench for rr_req_buffer (num_reqs=4, DATA_W=32, DEPTH=4).
// Stimulus pushes the expected {port, data} of every grant that should pop
// into a queue; an independent monitor compares each out_valid beat against
// the queue head. Combinational outputs are checked at the falling edge.
// -----------------------------------------------------------------------------
module tb_rr_req_buffer;

    localparam int NR = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    in_valid;
    logic [NR*DW-1:0] in_data;
    logic [NR-1:0]    in_ready;
    logic [NR-1:0]    reqs;
    logic [NR-1:0]    grants;
    logic             out_valid;
    logic [1:0]       out_port;
    logic [DW-1:0]    out_data;
`ifdef RR_REQ_BUF_ERR_EN
    logic             err_sticky;
    logic [1:0]       err_code;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    rr_req_buffer #(
        .num_reqs (NR),
        .DATA_W   (DW),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reqs      (reqs),
        .grants    (grants),
        .out_valid (out_valid),
        .out_port  (out_port),
        .out_data  (out_data)
`ifdef RR_REQ_BUF_ERR_EN
        ,
        .err_sticky (err_sticky),
        .err_code   (err_code)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the falling edge of the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_data(input int p, input logic [DW-1:0] d);
        in_data[p*DW +: DW] = d;
    endtask

    task automatic expect_out(input logic [1:0] p, input logic [DW-1:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got port %0d data %h, required no output",
                         out_port, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_port !== e.port || out_data !== e.data) begin
                    n_err++;
                    $display("FAIL out_beat: got port %0d data %h, required port %0d data %h",
                             out_port, out_data, e.port, e.data);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_data  = '0;
        grants   = '0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        sample();
        check("rst_reqs",      32'(reqs),      32'h0);
        check("rst_in_ready",  32'(in_ready),  32'hF);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_port",  32'(out_port),  32'h0);
        check("rst_out_data",  out_data,       32'h0);
`ifdef RR_REQ_BUF_ERR_EN
        check("rst_err_code",  32'(err_code),  32'h0);
`endif

        // ---------------- Single push / grant on port 2 ----------------
        tick();
        reset    = 1'b0;
        in_valid = 4'b0100;
        set_data(2, 32'hA5A5_0001);
        tick();
        in_valid = '0;
        sample();
        check("t1_reqs_after_push", 32'(reqs), 32'h4);
        tick();
        grants = 4'b0100;
        expect_out(2'd2, 32'hA5A5_0001);
        sample();
        check("t1_reqs_masked", 32'(reqs), 32'h0);
        tick();
        grants = '0;
        sample();

        // ---------------- Fill port 0, overflow attempt, drain ----------------
        in_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_data(0, 32'h10 + 32'(k));
            tick();
            sample();
            check($sformatf("t2_ready_after_push%0d", k + 1), 32'(in_ready[0]),
                  (k < 3) ? 32'h1 : 32'h0);
        end
        set_data(0, 32'h14);                 // fifth push attempt while full
        tick();
        in_valid = '0;
        grants   = 4'b0001;
        expect_out(2'd0, 32'h10);
        sample();
        check("t2_ready_full_during_pop", 32'(in_ready[0]), 32'h0);
        tick();
        expect_out(2'd0, 32'h11);
        sample();
        check("t2_ready_after_pop", 32'(in_ready[0]), 32'h1);
        tick();
        expect_out(2'd0, 32'h12);
        tick();
        expect_out(2'd0, 32'h13);
        sample();
        check("t2_reqs_last_pop", 32'(reqs), 32'h0);
        tick();
        grants = '0;
        sample();
        check("t2_reqs_drained", 32'(reqs), 32'h0);

        // ---------------- Ports 0,1,3 granted in sequence ----------------
        tick();
        in_valid = 4'b1011;
        set_data(0, 32'h20);
        set_data(1, 32'h21);
        set_data(3, 32'h23);
        tick();
        in_valid = '0;
        sample();
        check("t3_reqs_loaded", 32'(reqs), 32'hB);
        tick();
        grants = 4'b0001;
        expect_out(2'd0, 32'h20);
        sample();
        check("t3_reqs_g0", 32'(reqs), 32'hA);
        tick();
        grants = 4'b0010;
        expect_out(2'd1, 32'h21);
        sample();
        check("t3_reqs_g1", 32'(reqs), 32'h8);
        tick();
        grants = 4'b1000;
        expect_out(2'd3, 32'h23);
        sample();
        check("t3_reqs_g3", 32'(reqs), 32'h0);
        tick();
        grants = '0;

        // ---------------- Simultaneous push and pop on port 1 ----------------
        tick();
        in_valid = 4'b0010;
        set_data(1, 32'h30);
        tick();
        grants = 4'b0010;
        set_data(1, 32'h31);
        expect_out(2'd1, 32'h30);
        sample();
        check("t4_reqs_pushpop", 32'(reqs), 32'h0);
        tick();
        grants   = '0;
        in_valid = '0;
        sample();
        check("t4_reqs_next", 32'(reqs), 32'h2);
        tick();
        grants = 4'b0010;
        expect_out(2'd1, 32'h31);
        sample();
        check("t4_reqs_drain", 32'(reqs), 32'h0);
        tick();
        grants = '0;

        // ---------------- Grant to an empty port ----------------
        tick();
        grants = 4'b0010;
        tick();
        grants = '0;
        sample();
        check("t5_no_output", 32'(out_valid), 32'h0);
        check("t5_reqs", 32'(reqs), 32'h0);
`ifdef RR_REQ_BUF_ERR_EN
        check("t5_err_code", 32'(err_code), 32'h1);
        check("t5_err_sticky", 32'(err_sticky), 32'h1);
`endif
        // Pointers must be intact: a fresh entry pops with its own data.
        tick();
        in_valid = 4'b0010;
        set_data(1, 32'h40);
        tick();
        in_valid = '0;
        grants   = 4'b0010;
        expect_out(2'd1, 32'h40);
        tick();
        grants = '0;
        sample();
`ifdef RR_REQ_BUF_ERR_EN
        check("t5_err_still", 32'(err_code), 32'h1);
`endif

        // ---------------- Multi-hot grant: lowest non-empty wins ----------------
        tick();
        in_valid = 4'b0101;
        set_data(0, 32'h50);
        set_data(2, 32'h52);
        tick();
        in_valid = '0;
        grants   = 4'b0101;
        expect_out(2'd0, 32'h50);
        sample();
        check("t6_reqs_multihot", 32'(reqs), 32'h0);
        tick();
        grants = 4'b0100;
        expect_out(2'd2, 32'h52);
        tick();
        grants = '0;
        sample();
        check("t6_reqs_after", 32'(reqs), 32'h0);
`ifdef RR_REQ_BUF_ERR_EN
        check("t6_err_code", 32'(err_code), 32'h3);
`endif

        // ---------------- Reset mid-operation ----------------
        tick();
        in_valid = 4'b0100;
        set_data(2, 32'h60);
        tick();
        set_data(2, 32'h61);
        tick();
        set_data(2, 32'h62);
        tick();
        in_valid = '0;
        grants   = 4'b0100;
        expect_out(2'd2, 32'h60);
        tick();
        grants = '0;
        reset  = 1'b1;
        sample();
        check("t7_out_valid_inflight", 32'(out_valid), 32'h1);
        tick();
        sample();
        check("t7_rst_reqs",      32'(reqs),      32'h0);
        check("t7_rst_out_valid", 32'(out_valid), 32'h0);
        check("t7_rst_in_ready",  32'(in_ready),  32'hF);
        check("t7_rst_out_data",  out_data,       32'h0);
`ifdef RR_REQ_BUF_ERR_EN
        check("t7_rst_err_code",  32'(err_code),  32'h0);
`endif
        tick();
        reset  = 1'b0;
        grants = 4'b0100;
        tick();
        grants = '0;
        sample();
        check("t7_no_output_after_rst", 32'(out_valid), 32'h0);
        check("t7_reqs_after_rst", 32'(reqs), 32'h0);

        tick();
        tick();
        check("all_expected_consumed", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
